nmr_pulse_train_streamer: RTL and testbench
===========================================

// Module: nmr_pulse_train_streamer
// PURPOSE
//  Multi-pulse successor to the single-pulse NMR bit streamer: emits one excitation pulse,
//  then NREP refocusing pulse/acquire-delay pairs (CPMG or phase-alternated train).
//  Drives the TX gate bit, a quadrature phase code and an acquisition-window strobe.
//  Sits between the sequencer controller (START/DONE handshake) and the TX/ADC gating logic.
// PARAMETERS
//  CNT_WIDTH    32  width of every segment length input, in CLK cycles
//  NREP_WIDTH   16  width of the refocusing-repetition count
//  PHASE_WIDTH   2  width of the phase code (2 = 0/90/180/270 deg)
// PORTS
//  CLK      in   1           system clock
//  RST      in   1           reset, asynchronous, active-high
//  START    in   1           level request; sampled in IDLE, must drop before next run
//  ABORT    in   1           synchronous abort of a running train
//  idly     in   CNT_WIDTH   initial delay length
//  pls1     in   CNT_WIDTH   excitation pulse length
//  dly1     in   CNT_WIDTH   delay after excitation (tau)
//  pls2     in   CNT_WIDTH   refocusing pulse length
//  dly2     in   CNT_WIDTH   delay after each refocusing pulse (acquisition window)
//  nrep     in   NREP_WIDTH  number of pls2/dly2 pairs
//  ph1      in   PHASE_WIDTH excitation phase code
//  ph2      in   PHASE_WIDTH refocusing phase code
//  alt      in   1           1 = add 180 deg (2^(PHASE_WIDTH-1), mod 2^PHASE_WIDTH) to ph2 on odd reps
//  OUT      out  1           TX gate, high during pulses
//  PHASE    out  PHASE_WIDTH phase code of current/last pulse
//  ACQ_EN   out  1           high during every dly2 segment
//  REP_IDX  out  NREP_WIDTH  index of current refocusing pair (0-based)
//  BUSY     out  1           high in any state other than IDLE/FIN
//  DONE     out  1           high in IDLE and FIN
// BEHAVIOUR
//  Reset: state IDLE; OUT=0, PHASE=0, ACQ_EN=0, REP_IDX=0, BUSY=0, DONE=0. DONE rises on the
//   first edge after RST deasserts. RST mid-train aborts immediately, no glitch on OUT.
//  All outputs registered, Moore-style: they change on the edge that enters a state.
//  States: IDLE, IDLY, P1, D1, P2, D2, FIN.
//  IDLE: DONE=1. START high at edge k latches all inputs (later input changes ignored); state
//   moves on edge k to the first non-zero segment (first segment's outputs visible after edge k).
//  Segment order: IDLY(OUT=0) > P1(OUT=1,PHASE=ph1) > D1(OUT=0) > {P2(OUT=1,PHASE=ph2') >
//   D2(OUT=0,ACQ_EN=1)} x nrep > FIN.  ph2' = ph2, or ph2+180deg when alt=1 and REP_IDX odd.
//  Segment of length L holds its outputs for exactly L cycles; length 0 = segment skipped
//   (zero cycles), next non-zero segment entered directly. nrep=0: D1 goes straight to FIN.
//  Down-counter of CNT_WIDTH loaded with L on segment entry; leave when count==1.
//  REP_IDX increments on each D2->P2 transition; wraps are impossible (bounded by nrep).
//  PHASE holds last pulse phase through delays; reset to 0 only by RST.
//  FIN: DONE=1, BUSY=0, OUT=0, ACQ_EN=0; returns to IDLE the edge after START is seen low.
//   START still high in FIN never re-triggers.
//  ABORT high in IDLY..D2: next edge enters FIN (OUT=0, ACQ_EN=0). Ignored in IDLE/FIN.
//   ABORT and START both high in IDLE: START wins (abort applies only to a running train).
//  All segments zero and nrep=0: START goes IDLE->FIN in one edge.
// TESTING
//  idly=3,pls1=2,dly1=4,pls2=3,dly2=5,nrep=2,alt=0, START at edge k -> OUT high k+3..k+4,
//   k+9..k+11, k+17..k+19; ACQ_EN high k+12..k+16, k+20..k+24; FIN/DONE=1 at k+25.
//  Same timing, ph2=1, alt=1 -> PHASE=1 in rep 0, PHASE=3 in rep 1; REP_IDX 0 then 1.
//  pls1=0, idly=0, nrep=1 -> D1 entered at edge k, P2 follows; no OUT pulse before P2.
//  ABORT pulsed in mid-P2 of rep 1 -> OUT low next edge, DONE=1, no further ACQ_EN.
//  START held high through FIN for 10 cycles -> stays in FIN; drop START -> IDLE next edge.
//  RST asserted mid-P1 -> all outputs at reset values immediately; new START runs cleanly.

Source files
------------

// File: rtl/nmr_pulse_train_streamer.sv
// nmr_pulse_train_streamer
//   Generates an NMR pulse train. The order is: initial delay, then an
//   excitation pulse and tau, then nrep refocusing-pulse/acquire-delay pairs
//   (CPMG, or phase-alternated when alt=1). Every output is registered and
//   follows the state being entered (Moore).
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   START             level request, sampled in IDLE (latches all inputs)
//   ABORT             synchronous abort of a running train
//   idly..dly2        segment lengths in CLK cycles (0 = segment skipped)
//   nrep              number of pls2/dly2 pairs
//   ph1, ph2, alt     phase codes; alt adds 180 deg to ph2 on odd reps
//   OUT               TX gate (high during pulses)
//   PHASE             phase code of current/last pulse
//   ACQ_EN            acquisition window (high during dly2)
//   REP_IDX           current refocusing pair index (0-based)
//   BUSY / DONE       running / idle-or-finished status
module nmr_pulse_train_streamer #(
    parameter int CNT_WIDTH   = 32,
    parameter int NREP_WIDTH  = 16,
    parameter int PHASE_WIDTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [CNT_WIDTH-1:0]   idly,
    input  logic [CNT_WIDTH-1:0]   pls1,
    input  logic [CNT_WIDTH-1:0]   dly1,
    input  logic [CNT_WIDTH-1:0]   pls2,
    input  logic [CNT_WIDTH-1:0]   dly2,
    input  logic [NREP_WIDTH-1:0]  nrep,
    input  logic [PHASE_WIDTH-1:0] ph1,
    input  logic [PHASE_WIDTH-1:0] ph2,
    input  logic                   alt,
    output logic                   OUT,
    output logic [PHASE_WIDTH-1:0] PHASE,
    output logic                   ACQ_EN,
    output logic [NREP_WIDTH-1:0]  REP_IDX,
    output logic                   BUSY,
    output logic                   DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_IDLY, S_P1, S_D1, S_P2, S_D2, S_FIN
    } state_t;

    localparam logic [PHASE_WIDTH-1:0] HALF_TURN = PHASE_WIDTH'(1) << (PHASE_WIDTH - 1);

    state_t                 state, nxt_state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   load;
    logic [NREP_WIDTH-1:0]  nxt_rep;

    // Parameters latched at START
    logic [CNT_WIDTH-1:0]   idly_q, pls1_q, dly1_q, pls2_q, dly2_q;
    logic [NREP_WIDTH-1:0]  nrep_q;
    logic [PHASE_WIDTH-1:0] ph1_q, ph2_q;
    logic                   alt_q;

    // The entry decision on the START edge must use the live inputs, because
    // the latched copies only become valid after that edge.
    logic                   in_idle;
    logic [CNT_WIDTH-1:0]   e_idly, e_pls1, e_dly1, e_pls2, e_dly2;
    logic [NREP_WIDTH-1:0]  e_nrep;
    logic [PHASE_WIDTH-1:0] e_ph1, e_ph2;
    logic                   e_alt;

    assign in_idle = (state == S_IDLE);
    assign e_idly  = in_idle ? idly : idly_q;
    assign e_pls1  = in_idle ? pls1 : pls1_q;
    assign e_dly1  = in_idle ? dly1 : dly1_q;
    assign e_pls2  = in_idle ? pls2 : pls2_q;
    assign e_dly2  = in_idle ? dly2 : dly2_q;
    assign e_nrep  = in_idle ? nrep : nrep_q;
    assign e_ph1   = in_idle ? ph1  : ph1_q;
    assign e_ph2   = in_idle ? ph2  : ph2_q;
    assign e_alt   = in_idle ? alt  : alt_q;

    // First non-empty segment of a refocusing pair, or FIN if there is none
    logic [NREP_WIDTH:0] rep_inc;
    logic                more_reps;
    state_t              pair_state, rep0_state, repn_state;

    assign rep_inc    = {1'b0, REP_IDX} + (NREP_WIDTH + 1)'(1);
    assign more_reps  = rep_inc < {1'b0, e_nrep};
    assign pair_state = (e_pls2 != '0) ? S_P2 : ((e_dly2 != '0) ? S_D2 : S_FIN);
    assign rep0_state = (e_nrep != '0) ? pair_state : S_FIN;
    assign repn_state = more_reps ? pair_state : S_FIN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        nxt_rep   = REP_IDX;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    load    = 1'b1;
                    nxt_rep = '0;
                    if (e_idly != '0)      nxt_state = S_IDLY;
                    else if (e_pls1 != '0) nxt_state = S_P1;
                    else if (e_dly1 != '0) nxt_state = S_D1;
                    else                   nxt_state = rep0_state;
                end
            end
            S_IDLY, S_P1, S_D1, S_P2, S_D2: begin
                if (ABORT) begin
                    nxt_state = S_FIN;
                end else if (cnt == CNT_WIDTH'(1)) begin
                    load = 1'b1;
                    case (state)
                        S_IDLY: begin
                            if (e_pls1 != '0)      nxt_state = S_P1;
                            else if (e_dly1 != '0) nxt_state = S_D1;
                            else                   nxt_state = rep0_state;
                        end
                        S_P1: nxt_state = (e_dly1 != '0) ? S_D1 : rep0_state;
                        S_D1: nxt_state = rep0_state;
                        S_P2: begin
                            if (e_dly2 != '0) begin
                                nxt_state = S_D2;
                            end else begin
                                nxt_state = repn_state;
                                if (more_reps) nxt_rep = rep_inc[NREP_WIDTH-1:0];
                            end
                        end
                        default: begin
                            nxt_state = repn_state;
                            if (more_reps) nxt_rep = rep_inc[NREP_WIDTH-1:0];
                        end
                    endcase
                end
            end
            default: begin
                if (!START) nxt_state = S_IDLE;
            end
        endcase
    end

    logic [CNT_WIDTH-1:0]   nxt_len;
    logic [PHASE_WIDTH-1:0] ph2_eff;

    always_comb begin
        nxt_len = '0;
        case (nxt_state)
            S_IDLY:  nxt_len = e_idly;
            S_P1:    nxt_len = e_pls1;
            S_D1:    nxt_len = e_dly1;
            S_P2:    nxt_len = e_pls2;
            S_D2:    nxt_len = e_dly2;
            default: nxt_len = '0;
        endcase
    end

    assign ph2_eff = (e_alt && nxt_rep[0]) ? (e_ph2 + HALF_TURN) : e_ph2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            idly_q  <= '0;
            pls1_q  <= '0;
            dly1_q  <= '0;
            pls2_q  <= '0;
            dly2_q  <= '0;
            nrep_q  <= '0;
            ph1_q   <= '0;
            ph2_q   <= '0;
            alt_q   <= 1'b0;
            OUT     <= 1'b0;
            PHASE   <= '0;
            ACQ_EN  <= 1'b0;
            REP_IDX <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            if (in_idle && START) begin
                idly_q <= idly;
                pls1_q <= pls1;
                dly1_q <= dly1;
                pls2_q <= pls2;
                dly2_q <= dly2;
                nrep_q <= nrep;
                ph1_q  <= ph1;
                ph2_q  <= ph2;
                alt_q  <= alt;
            end
            if (load)            cnt <= nxt_len;
            else if (cnt != '0)  cnt <= cnt - CNT_WIDTH'(1);
            // PHASE only moves when a pulse is entered and holds through delays
            if (load && nxt_state == S_P1)      PHASE <= e_ph1;
            else if (load && nxt_state == S_P2) PHASE <= ph2_eff;
            OUT     <= (nxt_state == S_P1) || (nxt_state == S_P2);
            ACQ_EN  <= (nxt_state == S_D2);
            REP_IDX <= nxt_rep;
            BUSY    <= (nxt_state != S_IDLE) && (nxt_state != S_FIN);
            DONE    <= (nxt_state == S_IDLE) || (nxt_state == S_FIN);
        end
    end

endmodule

// File: tb/tb_nmr_pulse_train_streamer.sv
// Testbench for nmr_pulse_train_streamer. The stimulus process queues the
// expected per-cycle output bundle for each run. A monitor pops one entry
// per cycle on the falling edge and compares it.
module tb_nmr_pulse_train_streamer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [31:0] idly = '0, pls1 = '0, dly1 = '0, pls2 = '0, dly2 = '0;
    logic [15:0] nrep = '0;
    logic [1:0]  ph1 = '0, ph2 = '0;
    logic        alt = 1'b0;
    logic        OUT;
    logic [1:0]  PHASE;
    logic        ACQ_EN;
    logic [15:0] REP_IDX;
    logic        BUSY, DONE;

    typedef struct packed {
        logic        out;
        logic [1:0]  ph;
        logic        acq;
        logic [15:0] rep;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    failures = 0;
    int    item = 0;
    string tname = "reset";

    nmr_pulse_train_streamer #(.CNT_WIDTH(32), .NREP_WIDTH(16), .PHASE_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .idly(idly), .pls1(pls1), .dly1(dly1), .pls2(pls2), .dly2(dly2),
        .nrep(nrep), .ph1(ph1), .ph2(ph2), .alt(alt),
        .OUT(OUT), .PHASE(PHASE), .ACQ_EN(ACQ_EN), .REP_IDX(REP_IDX),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Monitor: one expected bundle per cycle while the scoreboard holds entries
    initial begin
        exp_t e, a;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{OUT, PHASE, ACQ_EN, REP_IDX, BUSY, DONE};
                checks++;
                item++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s item %0d: got out=%b ph=%0d acq=%b rep=%0d busy=%b done=%b, expected out=%b ph=%0d acq=%b rep=%0d busy=%b done=%b",
                             tname, item, a.out, a.ph, a.acq, a.rep, a.busy, a.done,
                             e.out, e.ph, e.acq, e.rep, e.busy, e.done);
                end
            end
        end
    end

    // Running segment: busy, not done
    task automatic seg(input int n, input bit o, input int ph, input bit acq, input int rep);
        for (int i = 0; i < n; i++)
            sb.push_back('{o, 2'(ph), acq, 16'(rep), 1'b0 | 1'b1, 1'b0});
    endtask

    // IDLE/FIN cycles: done, not busy, gates low
    task automatic fin(input int n, input int ph, input int rep);
        for (int i = 0; i < n; i++)
            sb.push_back('{1'b0, 2'(ph), 1'b0, 16'(rep), 1'b0, 1'b1});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge CLK); #1;
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s drain: %0d entries left, expected 0", tname, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset(input string nm);
        checks++;
        if ({OUT, PHASE, ACQ_EN, REP_IDX, BUSY, DONE} !== 22'd0) begin
            failures++;
            $display("FAIL %s: got out=%b ph=%0d acq=%b rep=%0d busy=%b done=%b, expected all zero",
                     nm, OUT, PHASE, ACQ_EN, REP_IDX, BUSY, DONE);
        end
    endtask

    task automatic set_in(input int i_idly, input int p1, input int d1, input int p2,
                          input int d2, input int n, input int f1, input int f2, input bit a);
        idly = 32'(i_idly); pls1 = 32'(p1); dly1 = 32'(d1); pls2 = 32'(p2); dly2 = 32'(d2);
        nrep = 16'(n); ph1 = 2'(f1); ph2 = 2'(f2); alt = a;
    endtask

    // Issue START for one edge, then drop it and scramble inputs (must be ignored)
    task automatic go(input bit ab);
        ABORT = ab;
        START = 1'b1;
        @(negedge CLK); #1;
        START = 1'b0;
        ABORT = 1'b0;
        set_in(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
               int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    // Reference train: idly=3 pls1=2 dly1=4 pls2=3 dly2=5 nrep=2
    task automatic push_ref(input int ph0, input int p1, input int pr0, input int pr1);
        seg(3, 0, ph0, 0, 0);
        seg(2, 1, p1, 0, 0);
        seg(4, 0, p1, 0, 0);
        seg(3, 1, pr0, 0, 0);
        seg(5, 0, pr0, 1, 0);
        seg(3, 1, pr1, 0, 1);
        seg(5, 0, pr1, 1, 1);
        fin(2, pr1, 1);
    endtask

    initial begin
        // Reset held: everything zero, including DONE
        @(negedge CLK); @(negedge CLK); #1;
        check_reset("reset_hold");
        RST = 1'b0;
        tname = "reset_release";
        fin(1, 0, 0);
        drain();

        // All segments zero, nrep=0: IDLE->FIN in one edge, then back to IDLE
        tname = "all_zero";
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        fin(2, 0, 0);
        go(0);
        drain();

        // Reference CPMG train
        tname = "cpmg";
        set_in(3, 2, 4, 3, 5, 2, 1, 2, 0);
        push_ref(0, 1, 2, 2);
        go(0);
        drain();

        // Phase alternation: ph2=1 -> 1 on rep 0, 3 on rep 1
        tname = "alt";
        set_in(3, 2, 4, 3, 5, 2, 0, 1, 1);
        push_ref(2, 0, 1, 3);
        go(0);
        drain();

        // idly=pls1=0: D1 entered on the START edge; ABORT with START is ignored
        tname = "skip_start";
        set_in(0, 0, 4, 3, 2, 1, 1, 2, 1);
        seg(4, 0, 3, 0, 0);
        seg(3, 1, 2, 0, 0);
        seg(2, 0, 2, 1, 0);
        fin(2, 2, 0);
        go(1);
        drain();

        // ABORT in the first cycle of rep-1 P2: FIN on the next edge
        tname = "abort";
        set_in(3, 2, 4, 3, 5, 2, 1, 2, 0);
        seg(3, 0, 2, 0, 0);
        seg(2, 1, 1, 0, 0);
        seg(4, 0, 1, 0, 0);
        seg(3, 1, 2, 0, 0);
        seg(5, 0, 2, 1, 0);
        seg(1, 1, 2, 0, 1);
        fin(2, 2, 1);
        go(0);
        repeat (17) @(negedge CLK);
        #1 ABORT = 1'b1;
        @(negedge CLK); #1 ABORT = 1'b0;
        drain();

        // START held through FIN: no re-trigger; drop -> IDLE next edge
        tname = "hold_start";
        set_in(0, 2, 1, 0, 0, 0, 3, 0, 0);
        seg(2, 1, 3, 0, 0);
        seg(1, 0, 3, 0, 0);
        fin(11, 3, 0);
        START = 1'b1;
        repeat (13) @(negedge CLK);
        #1 START = 1'b0;
        drain();

        // A new run starts, which proves the block returned to IDLE
        tname = "after_hold";
        set_in(0, 2, 1, 0, 0, 0, 3, 0, 0);
        seg(2, 1, 3, 0, 0);
        seg(1, 0, 3, 0, 0);
        fin(2, 3, 0);
        go(0);
        drain();

        // RST mid-P1: outputs reset immediately, without waiting for an edge
        tname = "rst_mid";
        set_in(1, 4, 2, 0, 0, 0, 1, 0, 0);
        seg(1, 0, 3, 0, 0);
        seg(2, 1, 1, 0, 0);
        go(0);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b1;
        #1 check_reset("rst_mid_async");
        @(negedge CLK); #1 RST = 1'b0;
        tname = "rst_release";
        fin(1, 0, 0);
        drain();

        // Clean run after reset
        tname = "cpmg_after_rst";
        set_in(3, 2, 4, 3, 5, 2, 1, 2, 0);
        push_ref(0, 1, 2, 2);
        go(0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
